// File: rtl/lfsr_stream_checker_if.sv
// Port bundle between an LFSR stream source/stimulus (master) and the
// lfsr_stream_checker (slave).
interface lfsr_stream_checker_if #(
    parameter int WIDTH = 8
);
    // start/seed are sampled only while the checker is IDLE. in_bit is taken on
    // every rising edge with in_valid=1 in RECEIVE; there is no ready because the
    // checker never stalls the source. A valid bit outside RECEIVE is dropped and
    // raises the sticky stray flag.
    logic                       start;
    logic [WIDTH-1:0]           seed;
    logic                       in_bit;
    logic                       in_valid;
    logic                       busy;
    logic                       done;
    logic                       match;
    logic [WIDTH-1:0]           rx_word;
    logic [WIDTH-1:0]           exp_word;
    logic [$clog2(WIDTH+1)-1:0] bit_errs;
    logic                       stray;

    modport master (
        output start, seed, in_bit, in_valid,
        input  busy, done, match, rx_word, exp_word, bit_errs, stray
    );

    modport slave (
        input  start, seed, in_bit, in_valid,
        output busy, done, match, rx_word, exp_word, bit_errs, stray
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Sink-side LFSR stream checker: replays the generator's LFSR from the seed,
// deserializes an LSB-first word and reports match and bit-error count.
module lfsr_stream_checker #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'b10111000,
    parameter int               STEPS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_stream_checker_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADVANCE = 2'd1,
        S_RECEIVE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam int EW  = $clog2(WIDTH + 1);
    localparam int SCW = $clog2(STEPS + 2);
    localparam int BCW = $clog2(WIDTH);
    localparam logic [SCW-1:0] STEP_LAST = SCW'((STEPS > 0) ? STEPS - 1 : 0);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [SCW-1:0]   step_cnt_q, step_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic             match_q, match_d;
    logic [EW-1:0]    errs_q, errs_d;
    logic             stray_q, stray_d;
    logic             fb;
    logic [WIDTH-1:0] rx_shift;
    logic [EW-1:0]    errs_next;

    assign fb       = ^(lfsr_q & TAPS);
    assign rx_shift = {bus.in_bit, rx_q[WIDTH-1:1]};

    // Error count is taken from the word as it will look after the final shift.
    always_comb begin
        errs_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            errs_next = errs_next + EW'(rx_shift[i] ^ lfsr_q[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        rx_d       = rx_q;
        step_cnt_d = step_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        match_d    = match_q;
        errs_d     = errs_q;
        stray_d    = stray_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lfsr_d     = bus.seed;
                    rx_d       = '0;
                    match_d    = 1'b0;
                    errs_d     = '0;
                    stray_d    = 1'b0;
                    step_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = (STEPS == 0) ? S_RECEIVE : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                lfsr_d     = {lfsr_q[WIDTH-2:0], fb};
                step_cnt_d = step_cnt_q + 1'b1;
                if (step_cnt_q == STEP_LAST) begin
                    state_d = S_RECEIVE;
                end
            end
            S_RECEIVE: begin
                if (bus.in_valid) begin
                    rx_d      = rx_shift;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        match_d = (rx_shift == lfsr_q);
                        errs_d  = errs_next;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Applied after the start clear so a same-cycle stray bit still sticks.
        if (bus.in_valid && (state_q != S_RECEIVE)) begin
            stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= '0;
            rx_q       <= '0;
            step_cnt_q <= '0;
            bit_cnt_q  <= '0;
            match_q    <= 1'b0;
            errs_q     <= '0;
            stray_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            rx_q       <= rx_d;
            step_cnt_q <= step_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            match_q    <= match_d;
            errs_q     <= errs_d;
            stray_q    <= stray_d;
        end
    end

    assign bus.busy     = (state_q == S_ADVANCE) || (state_q == S_RECEIVE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.match    = match_q;
    assign bus.rx_word  = rx_q;
    assign bus.exp_word = lfsr_q;
    assign bus.bit_errs = errs_q;
    assign bus.stray    = stray_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Bench for lfsr_stream_checker: table vectors, hand-written corner sequences
// and randomized runs against an arithmetic LFSR reference model.
module tb_lfsr_stream_checker;
    localparam int         W     = 8;
    localparam logic [7:0] TAPS  = 8'b10111000;
    localparam int         STEPS = 8;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] word;
        int         gap_pos;
        int         gap_len;
        bit         adv_valid;
        bit         start_valid;
        int         restart_at;
        logic [7:0] exp_word;
        bit         exp_match;
        int         exp_errs;
        int         exp_lat;
        bit         exp_stray;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lfsr_stream_checker_if #(.WIDTH(W)) bus ();
    lfsr_stream_checker_if #(.WIDTH(W)) bus0 ();
    logic [1:0] dbg_state, dbg_state0;

    lfsr_stream_checker #(.WIDTH(W), .TAPS(TAPS), .STEPS(STEPS)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
    );
    lfsr_stream_checker #(.WIDTH(W), .TAPS(TAPS), .STEPS(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .dbg_state_o(dbg_state0)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];
    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    // Done monitors: capture results while done is high.
    int         done_cnt = 0, done_cyc = 0, done0_cnt = 0, done0_cyc = 0;
    logic       dm_match, dm_busy, dm0_match;
    logic [7:0] dm_rx, dm_exp;
    logic [3:0] dm_errs;
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            done_cnt++; done_cyc = cyc;
            dm_match = bus.match; dm_busy = bus.busy; dm_rx = bus.rx_word;
            dm_exp = bus.exp_word; dm_errs = bus.bit_errs;
        end
        if (bus0.done === 1'b1) begin
            done0_cnt++; done0_cyc = cyc; dm0_match = bus0.match;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_word(input logic [7:0] s, input int steps);
        logic [7:0] st;
        st = s;
        for (int k = 0; k < steps; k++) begin
            st = (st << 1) | 8'($countones(st & TAPS) % 2);
        end
        return st;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, " busy"},     bus.busy,     0);
        check({tag, " done"},     bus.done,     0);
        check({tag, " match"},    bus.match,    0);
        check({tag, " rx_word"},  bus.rx_word,  0);
        check({tag, " exp_word"}, bus.exp_word, 0);
        check({tag, " bit_errs"}, bus.bit_errs, 0);
        check({tag, " stray"},    bus.stray,    0);
        check({tag, " state"},    dbg_state,    0);
    endtask

    task automatic run(input vec_t v, input string tag);
        int e0, base_cnt;
        exp_q.push_back(v.exp_word);
        base_cnt = done_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.seed = v.seed; bus.in_valid = v.start_valid; bus.in_bit = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " busy_after_start"}, bus.busy, 1);
        for (int k = 0; k < STEPS; k++) begin
            bus.in_valid = v.adv_valid;
            bus.in_bit   = 1'($urandom_range(0, 1));
            bus.start    = (k == v.restart_at);
            bus.seed     = ~v.seed;
            @(negedge clk);
        end
        bus.start = 1'b0; bus.seed = v.seed;
        for (int i = 0; i < W; i++) begin
            if (i == v.gap_pos) begin
                for (int g = 0; g < v.gap_len; g++) begin
                    bus.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            bus.in_valid = 1'b1; bus.in_bit = v.word[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        #1;
        check({tag, " done_now"}, bus.done, 1);
        repeat (2) @(negedge clk);
        #1;
        check({tag, " done_pulses"}, done_cnt - base_cnt, 1);
        check({tag, " latency"},  done_cyc - e0 + 1, v.exp_lat);
        check({tag, " exp_word"}, dm_exp, exp_q.pop_front());
        check({tag, " match"},    dm_match, v.exp_match);
        check({tag, " bit_errs"}, dm_errs, v.exp_errs);
        check({tag, " busy_at_done"}, dm_busy, 0);
        check({tag, " rx_held"},  bus.rx_word, v.word);
        check({tag, " match_held"}, bus.match, v.exp_match);
        check({tag, " stray"},    bus.stray, v.exp_stray);
    endtask

    initial begin
        int base;
        int e0;
        vec_t rv;
        logic [7:0] mw;
        logic [7:0] w0;

        bus.start = 0; bus.seed = 0; bus.in_bit = 0; bus.in_valid = 0;
        bus0.start = 0; bus0.seed = 0; bus0.in_bit = 0; bus0.in_valid = 0;

        //        seed   word   gp gl adv sv  rst  exp    m  err lat stray
        vecs[0] = '{8'h01, 8'h1C, 0, 0, 0, 0, -1, 8'h1C, 1, 0, 17, 0};
        vecs[1] = '{8'h01, 8'h9D, 0, 0, 0, 0, -1, 8'h1C, 0, 2, 17, 0};
        vecs[2] = '{8'h01, 8'h1C, 4, 3, 1, 0, -1, 8'h1C, 1, 0, 20, 1};
        vecs[3] = '{8'h00, 8'h00, 0, 0, 0, 0, -1, 8'h00, 1, 0, 17, 0};
        vecs[4] = '{8'h00, 8'h00, 0, 0, 0, 0,  2, 8'h00, 1, 0, 17, 0};
        vecs[5] = '{8'h01, 8'hE3, 0, 0, 0, 0, -1, 8'h1C, 0, 8, 17, 0};
        vecs[6] = '{8'h01, 8'h1C, 0, 0, 0, 1, -1, 8'h1C, 1, 0, 17, 1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset");
        check("reset dut0 exp_word", bus0.exp_word, 0);
        check("reset dut0 busy", bus0.busy, 0);

        for (int n = 0; n < 7; n++) run(vecs[n], $sformatf("vec%0d", n));

        // Stray bit while IDLE, then a clean start must clear it.
        @(negedge clk); bus.in_valid = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0;
        #1 check("idle stray", bus.stray, 1);
        run(vecs[0], "clear_stray");

        // Reset after 4 received bits discards the run.
        base = done_cnt;
        @(negedge clk); bus.start = 1'b1; bus.seed = 8'h01;
        @(negedge clk); bus.start = 1'b0;
        repeat (STEPS) @(negedge clk);
        w0 = 8'h1C;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_bit = w0[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1 check_reset("midrst");
        repeat (12) @(negedge clk);
        check("midrst no_done", done_cnt - base, 0);
        run(vecs[0], "after_rst");

        // Randomized runs against the reference model.
        for (int r = 0; r < 20; r++) begin
            rv.seed        = 8'($urandom_range(0, 255));
            mw             = model_word(rv.seed, STEPS);
            rv.word        = ($urandom_range(0, 1) == 1) ? mw : (mw ^ 8'($urandom_range(0, 255)));
            rv.gap_pos     = $urandom_range(1, 7);
            rv.gap_len     = $urandom_range(0, 3);
            rv.adv_valid   = 1'($urandom_range(0, 1));
            rv.start_valid = 1'($urandom_range(0, 1));
            rv.restart_at  = $urandom_range(0, 8) - 1;
            rv.exp_word    = mw;
            rv.exp_match   = (rv.word == mw);
            rv.exp_errs    = $countones(rv.word ^ mw);
            rv.exp_lat     = STEPS + W + 1 + rv.gap_len;
            rv.exp_stray   = rv.adv_valid | rv.start_valid;
            run(rv, $sformatf("rand%0d", r));
        end

        // STEPS=0 build: word is the seed itself.
        base = done0_cnt;
        w0 = 8'hA5;
        @(negedge clk); bus0.start = 1'b1; bus0.seed = 8'hA5;
        e0 = cyc + 1;
        @(negedge clk);
        bus0.start = 1'b0; bus0.seed = 8'h00;
        for (int i = 0; i < W; i++) begin
            bus0.in_valid = 1'b1; bus0.in_bit = w0[i];
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("steps0 done_pulses", done0_cnt - base, 1);
        check("steps0 latency", done0_cyc - e0 + 1, 9);
        check("steps0 match", dm0_match, 1);
        check("steps0 rx_word", bus0.rx_word, 8'hA5);
        check("steps0 exp_word", bus0.exp_word, model_word(8'hA5, 0));

        check("scoreboard drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
